bmc_stream_decoder: RTL and testbench

Parametrised successor to the tracker's BMC decoder. It recovers biphase-mark (BMC) bits from a pre-synchronised sensor line and emits a sliding window of WORD_BITS bits every STRIDE bits. Each emitted word carries a timestamp and uses a valid/ready handshake, with error counting and overrun reporting. It sits between the per-sensor input synchronisers/envelope detector and the LFSR/polynomial matcher.

---
 rtl/bmc_pkg.sv | 25 ++
 rtl/bmc_stream_decoder_if.sv | 23 ++
 rtl/bmc_interval_classifier.sv | 43 ++++
 rtl/bmc_stream_decoder.sv | 153 +++++++++++++++
 tb/tb_bmc_stream_decoder.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bmc_pkg.sv
// Shared types and default thresholds for the BMC stream decoder.
package bmc_pkg;

    typedef enum logic [1:0] {SYM_NONE, SYM_SHORT, SYM_LONG, SYM_TIMEOUT} sym_e;

    typedef enum logic [1:0] {HUNT, RUN, HALF} state_e;

    localparam int unsigned WORD_BITS_DEF = 17;
    localparam int unsigned STRIDE_DEF    = 2;
    localparam int unsigned TOO_FAST_DEF  = 2;
    localparam int unsigned FAST_MAX_DEF  = 11;
    localparam int unsigned TIMEOUT_DEF   = 24;
    localparam int unsigned CNT_W_DEF     = 6;
    localparam int unsigned TS_W_DEF      = 24;
    localparam int unsigned ERR_W_DEF     = 8;

    // Glitches and over-long intervals both map to SYM_NONE.
    function automatic sym_e classify(input int unsigned iv, input int unsigned too_fast,
                                      input int unsigned fast_max, input int unsigned timeout);
        if (iv <= too_fast || iv > timeout) return SYM_NONE;
        if (iv <= fast_max) return SYM_SHORT;
        return SYM_LONG;
    endfunction

endpackage

// File: rtl/bmc_stream_decoder_if.sv
// Output word stream plus status of the BMC decoder.
interface bmc_stream_decoder_if #(
    parameter int unsigned WORD_BITS = bmc_pkg::WORD_BITS_DEF,
    parameter int unsigned TS_W      = bmc_pkg::TS_W_DEF,
    parameter int unsigned ERR_W     = bmc_pkg::ERR_W_DEF
) ();
    logic [WORD_BITS-1:0] decoded_data;
    logic                 data_valid;
    logic [TS_W-1:0]      ts_last_data;
    logic                 out_ready;
    logic                 frame_overrun;
    logic [ERR_W-1:0]     err_count;

    modport master (
        output decoded_data, data_valid, ts_last_data, frame_overrun, err_count,
        input  out_ready
    );

    modport slave (
        input  decoded_data, data_valid, ts_last_data, frame_overrun, err_count,
        output out_ready
    );
endinterface

// File: rtl/bmc_interval_classifier.sv
// Tick counter between line edges; turns each accepted interval into a one-cycle symbol.
module bmc_interval_classifier
    import bmc_pkg::*;
#(
    parameter int unsigned TOO_FAST = TOO_FAST_DEF,
    parameter int unsigned FAST_MAX = FAST_MAX_DEF,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic clk_96MHz,
    input  logic reset,
    input  logic enabled_i,
    input  logic edge_i,
    output sym_e sym_o
);
    localparam logic [CNT_W-1:0] TooFast = CNT_W'(TOO_FAST);
    localparam logic [CNT_W-1:0] Timeout = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CntSat  = CNT_W'(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // An edge after saturation restarts the count without a symbol; the timeout was
    // already reported when the counter saturated.
    always_comb begin
        cnt_d = cnt_q;
        sym_o = SYM_NONE;
        if (enabled_i) begin
            if (edge_i && cnt_q > TooFast) begin
                cnt_d = CNT_W'(1);
                sym_o = classify(32'(cnt_q), TOO_FAST, FAST_MAX, TIMEOUT);
            end else if (cnt_q != CntSat) begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == Timeout) sym_o = SYM_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk_96MHz or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/bmc_stream_decoder.sv
// BMC bit recovery with sliding-window word output and valid/ready handshake.
// Define BMC_ERR_COUNT_EN to implement err_count; otherwise it is tied to zero.
module bmc_stream_decoder
    import bmc_pkg::*;
#(
    parameter int unsigned WORD_BITS = WORD_BITS_DEF,
    parameter int unsigned STRIDE    = STRIDE_DEF,
    parameter int unsigned TOO_FAST  = TOO_FAST_DEF,
    parameter int unsigned FAST_MAX  = FAST_MAX_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned TS_W      = TS_W_DEF,
    parameter int unsigned ERR_W     = ERR_W_DEF
) (
    input  logic            clk_96MHz,
    input  logic            reset,
    input  logic            enabled,
    input  logic            d_in_0,
    input  logic            d_in_1,
    input  logic            e_in_0,
    input  logic [TS_W-1:0] sys_ts,
    input  logic            clear_status,
    bmc_stream_decoder_if.master out_if
);
    localparam int unsigned BC_W = $clog2(WORD_BITS + 1);
    localparam int unsigned SC_W = $clog2(STRIDE + 1);
    localparam logic [BC_W-1:0] BcLast = BC_W'(WORD_BITS - 1);
    localparam logic [BC_W-1:0] BcFull = BC_W'(WORD_BITS);
    localparam logic [SC_W-1:0] StLast = SC_W'(STRIDE - 1);

    sym_e sym;
    logic edge_det;

    assign edge_det = (d_in_0 != d_in_1) && !e_in_0;

    bmc_interval_classifier #(
        .TOO_FAST (TOO_FAST),
        .FAST_MAX (FAST_MAX),
        .TIMEOUT  (TIMEOUT),
        .CNT_W    (CNT_W)
    ) u_classifier (
        .clk_96MHz (clk_96MHz),
        .reset     (reset),
        .enabled_i (enabled),
        .edge_i    (edge_det),
        .sym_o     (sym)
    );

    state_e               state_q;
    logic [WORD_BITS-1:0] shift_q, shift_nxt;
    logic [BC_W-1:0]      bit_cnt_q;
    logic [SC_W-1:0]      stride_q;
    logic [WORD_BITS-1:0] data_q;
    logic                 valid_q;
    logic [TS_W-1:0]      ts_q;
    logic                 overrun_q;
    logic                 shift_en, shift_bit, err_ev, emit;

    always_comb begin
        shift_en  = 1'b0;
        shift_bit = 1'b0;
        err_ev    = 1'b0;
        case (sym)
            SYM_SHORT: begin
                shift_en  = (state_q == HALF);
                shift_bit = 1'b1;
            end
            SYM_LONG: begin
                err_ev   = (state_q == HALF);
                shift_en = (state_q != HALF);
            end
            SYM_TIMEOUT: err_ev = 1'b1;
            default: ;
        endcase
        shift_nxt = (shift_q << 1) | WORD_BITS'(shift_bit);
        // First word when the window fills, then one per STRIDE new bits.
        emit = shift_en && ((bit_cnt_q == BcLast) || (bit_cnt_q == BcFull && stride_q == StLast));
    end

    always_ff @(posedge clk_96MHz or posedge reset) begin
        if (reset) begin
            state_q   <= HUNT;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            stride_q  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ts_q      <= '0;
            overrun_q <= 1'b0;
        end else begin
            case (sym)
                SYM_SHORT:   state_q <= (state_q == HALF) ? RUN : HALF;
                SYM_LONG:    state_q <= (state_q == HALF) ? HUNT : RUN;
                SYM_TIMEOUT: state_q <= HUNT;
                default: ;
            endcase

            if (err_ev) begin
                bit_cnt_q <= '0;
                stride_q  <= '0;
            end else if (shift_en) begin
                shift_q <= shift_nxt;
                if (bit_cnt_q != BcFull) begin
                    bit_cnt_q <= bit_cnt_q + BC_W'(1);
                    stride_q  <= '0;
                end else if (stride_q == StLast) begin
                    stride_q <= '0;
                end else begin
                    stride_q <= stride_q + SC_W'(1);
                end
            end

            // A reload on the accepting cycle wins over the clear.
            if (emit && (!valid_q || out_if.out_ready)) begin
                data_q  <= shift_nxt;
                ts_q    <= sys_ts;
                valid_q <= 1'b1;
            end else if (valid_q && out_if.out_ready) begin
                valid_q <= 1'b0;
            end

            if (clear_status) begin
                overrun_q <= 1'b0;
            end else if (emit && valid_q && !out_if.out_ready) begin
                overrun_q <= 1'b1;
            end
        end
    end

`ifdef BMC_ERR_COUNT_EN
    logic [ERR_W-1:0] err_q;

    always_ff @(posedge clk_96MHz or posedge reset) begin
        if (reset) begin
            err_q <= '0;
        end else if (clear_status) begin
            err_q <= '0;
        end else if (err_ev && state_q != HUNT && err_q != '1) begin
            err_q <= err_q + ERR_W'(1);
        end
    end

    assign out_if.err_count = err_q;
`else
    assign out_if.err_count = '0;
`endif

    assign out_if.decoded_data  = data_q;
    assign out_if.data_valid    = valid_q;
    assign out_if.ts_last_data  = ts_q;
    assign out_if.frame_overrun = overrun_q;

endmodule

// File: tb/tb_bmc_stream_decoder.sv
// Self-checking bench for bmc_stream_decoder against an interval-level BMC model.
module tb_bmc_stream_decoder;
    localparam int WB       = 17;
    localparam int STRIDE   = 2;
    localparam int TOO_FAST = 2;
    localparam int FAST_MAX = 11;
    localparam int TIMEOUT  = 24;
    localparam int TSW      = 24;
    localparam int EW       = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           enabled = 1'b1;
    logic           d_in_0 = 1'b0;
    logic           d_in_1 = 1'b0;
    logic           e_in_0 = 1'b0;
    logic           clear_status = 1'b0;
    logic [TSW-1:0] sys_ts = 24'h000123;

    always #5 clk = ~clk;

    bmc_stream_decoder_if #(.WORD_BITS(WB), .TS_W(TSW), .ERR_W(EW)) bus ();

    bmc_stream_decoder #(
        .WORD_BITS (WB),
        .STRIDE    (STRIDE),
        .TOO_FAST  (TOO_FAST),
        .FAST_MAX  (FAST_MAX),
        .TIMEOUT   (TIMEOUT),
        .CNT_W     (6),
        .TS_W      (TSW),
        .ERR_W     (EW)
    ) dut (
        .clk_96MHz    (clk),
        .reset        (rst),
        .enabled      (enabled),
        .d_in_0       (d_in_0),
        .d_in_1       (d_in_1),
        .e_in_0       (e_in_0),
        .sys_ts       (sys_ts),
        .clear_status (clear_status),
        .out_if       (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: interval accumulator, decoder phase, bit bookkeeping.
    int acc, st, nbits, since, errs, gcnt;
    logic [WB-1:0]  win;
    bit             emit_now;
    logic [WB-1:0]  exp_word;
    logic [TSW-1:0] exp_ts;
    bit             chk_en;
    int             words_seen;
    logic [WB-1:0]  last_word;
    logic [TSW-1:0] held_ts;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_err(input int e);
`ifdef BMC_ERR_COUNT_EN
        return e;
`else
        return 0 * e;
`endif
    endfunction

    task automatic model_reset();
        acc = -1; st = 0; nbits = 0; since = 0; errs = 0; gcnt = 0; win = '0;
    endtask

    task automatic model_err();
        if (st != 0 && errs < 255) errs++;
        st = 0; nbits = 0; since = 0;
    endtask

    task automatic push_bit(input bit b);
        win = {win[WB-2:0], b};
        if (nbits < WB) begin
            nbits++;
            if (nbits == WB) begin emit_now = 1; since = 0; end
        end else begin
            since++;
            if (since == STRIDE) begin emit_now = 1; since = 0; end
        end
        if (emit_now) exp_word = win;
    endtask

    // st: 0 = no bit in progress, 1 = at bit boundary, 2 = first half of a 1 seen.
    task automatic model_edge(input int g);
        int iv;
        iv = acc + g;
        if (iv <= TOO_FAST) begin
            acc = iv;
            return;
        end
        acc = 0;
        if (iv > TIMEOUT) begin
            model_err();
        end else if (iv <= FAST_MAX) begin
            if (st == 2) begin st = 1; push_bit(1'b1); end
            else st = 2;
        end else begin
            if (st == 2) model_err();
            else begin st = 1; push_bit(1'b0); end
        end
    endtask

    task automatic step(input bit tog, input bit mask, input bit en);
        d_in_1 = d_in_0;
        if (tog) d_in_0 = ~d_in_0;
        e_in_0  = mask;
        enabled = en;
        sys_ts  = sys_ts + 24'd5;
        emit_now = 0;
        if (en) gcnt++;
        if (tog && !mask && en) begin
            model_edge(gcnt);
            gcnt = 0;
            if (emit_now) exp_ts = sys_ts;
        end
        @(posedge clk);
        #1;
        if (bus.data_valid === 1'b1) begin
            words_seen++;
            last_word = bus.decoded_data;
        end
        if (chk_en) begin
            chk("valid", 32'(bus.data_valid), 32'(emit_now));
            if (emit_now) begin
                chk("word", 32'(bus.decoded_data), 32'(exp_word));
                chk("ts", 32'(bus.ts_last_data), 32'(exp_ts));
            end
        end
    endtask

    task automatic gap(input int g, input bit mask);
        repeat (g - 1) step(1'b0, 1'b0, 1'b1);
        step(1'b1, mask, 1'b1);
    endtask

    task automatic preamble();
        repeat (TIMEOUT + 4) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        d_in_0 = 1'b0; d_in_1 = 1'b0; e_in_0 = 1'b0;
        enabled = 1'b1; clear_status = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        words_seen = 0;
    endtask

    initial begin
        bus.out_ready = 1'b1;
        chk_en = 1'b1;
        do_reset();
        chk("rst_data", 32'(bus.decoded_data), 32'h0);
        chk("rst_valid", 32'(bus.data_valid), 32'h0);
        chk("rst_ts", 32'(bus.ts_last_data), 32'h0);
        chk("rst_overrun", 32'(bus.frame_overrun), 32'h0);
        chk("rst_err", 32'(bus.err_count), 32'h0);

        // 34 short intervals -> seventeen 1 bits
        preamble();
        words_seen = 0;
        repeat (34) gap(6, 1'b0);
        chk("t1_word", 32'(last_word), 32'h1FFFF);
        chk("t1_count", 32'(words_seen), 32'd1);

        // 17 zeros then two ones
        do_reset();
        preamble();
        repeat (17) gap(16, 1'b0);
        chk("t2_count0", 32'(words_seen), 32'd1);
        chk("t2_word0", 32'(last_word), 32'h0);
        repeat (4) gap(6, 1'b0);
        chk("t2_count1", 32'(words_seen), 32'd2);
        chk("t2_word1", 32'(last_word), 32'h3);

        // SHORT then LONG is an error; later timeout in HUNT is not
        do_reset();
        preamble();
        gap(6, 1'b0);
        gap(16, 1'b0);
        chk("t3_err", 32'(bus.err_count), 32'(exp_err(1)));
        gap(30, 1'b0);
        chk("t3_err_hunt", 32'(bus.err_count), 32'(exp_err(1)));
        words_seen = 0;
        repeat (17) gap(16, 1'b0);
        chk("t3_recover", 32'(words_seen), 32'd1);
        clear_status = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        clear_status = 1'b0;
        chk("t3_err_clr", 32'(bus.err_count), 32'h0);

        // 2-tick glitches inside a clean 6-tick short stream
        do_reset();
        preamble();
        repeat (34) begin
            gap(2, 1'b0);
            gap(4, 1'b0);
        end
        chk("t4_word", 32'(last_word), 32'h1FFFF);
        chk("t4_count", 32'(words_seen), 32'd1);

        // Backpressure: second word dropped, overrun sticky until cleared
        do_reset();
        chk_en = 1'b0;
        bus.out_ready = 1'b0;
        preamble();
        repeat (34) gap(6, 1'b0);
        held_ts = exp_ts;
        chk("t5_valid", 32'(bus.data_valid), 32'h1);
        chk("t5_word", 32'(bus.decoded_data), 32'h1FFFF);
        chk("t5_ovr0", 32'(bus.frame_overrun), 32'h0);
        repeat (4) gap(6, 1'b0);
        chk("t5_hold_valid", 32'(bus.data_valid), 32'h1);
        chk("t5_hold_word", 32'(bus.decoded_data), 32'h1FFFF);
        chk("t5_hold_ts", 32'(bus.ts_last_data), 32'(held_ts));
        chk("t5_ovr1", 32'(bus.frame_overrun), 32'h1);
        clear_status = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        clear_status = 1'b0;
        chk("t5_ovr_clr", 32'(bus.frame_overrun), 32'h0);
        chk("t5_err_clr", 32'(bus.err_count), 32'h0);
        bus.out_ready = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        chk("t5_drain", 32'(bus.data_valid), 32'h0);
        chk_en = 1'b1;

        // Asynchronous reset mid-word, then a fresh word with no stale bits
        do_reset();
        preamble();
        repeat (54) gap(6, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_data", 32'(bus.decoded_data), 32'h0);
        chk("t6_async_ts", 32'(bus.ts_last_data), 32'h0);
        chk("t6_async_valid", 32'(bus.data_valid), 32'h0);
        do_reset();
        preamble();
        repeat (17) gap(16, 1'b0);
        chk("t6_count", 32'(words_seen), 32'd1);
        chk("t6_word", 32'(last_word), 32'h0);

        // Randomised interval mix with glitches, masked edges, stalls and timeouts
        do_reset();
        preamble();
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if ($urandom_range(0, 9) == 0) repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, 1'b0);
            if (r < 45)      gap(int'($urandom_range(3, 11)), 1'b0);
            else if (r < 85) gap(int'($urandom_range(12, 24)), 1'b0);
            else if (r < 93) gap(int'($urandom_range(1, 2)), 1'b0);
            else if (r < 97) gap(int'($urandom_range(1, 10)), 1'b1);
            else             gap(int'($urandom_range(25, 30)), 1'b0);
        end
        gap(16, 1'b0);
        chk("rand_err", 32'(bus.err_count), 32'(exp_err(errs)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
